change_watch_ctrl: RTL
======================

Name: change_watch_ctrl

Overview:
- Hardware change-watchdog controller for a sampled signal or bus. It sequences monitoring of the signal and flags every sampling edge where the signal changed (pass) or stalled too long (fail).
- It is the synthesizable counterpart of the team's per-cycle "signal must change" property checks, and it also keeps pass/fail statistics for the stimulus or datapath it watches.
- It sits beside the driven signal, in the same clock domain, and can be read by a bench or a status register block.

Parameters:
- WIDTH, 1, width of the monitored signal sig_in.
- MAX_STALL, 0, number of consecutive unchanged samples tolerated before a fail (0 = the signal must change on every sample).
- CNT_W, 16, width of the pass, fail and stall counters.

Ports:
- clk  input  1  sampling clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  monitoring enable (level).
- clr  input  1  synchronous clear of counters and stall tracking.
- sig_in  input  WIDTH  monitored signal.
- pass_pulse  output  1  one-cycle pulse: a change was detected.
- fail_pulse  output  1  one-cycle pulse: stall limit exceeded.
- pass_cnt  output  CNT_W  total passes, saturating.
- fail_cnt  output  CNT_W  total fails, saturating.
- stall_cnt  output  CNT_W  current run of unchanged samples.
- state  output  2  FSM state: 0=IDLE, 1=PRIME, 2=WATCH.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, prev=0.
  - All counters 0; pass_pulse=0, fail_pulse=0, busy=0.
- IDLE:
  - No evaluation; pulses held at 0.
  - en=1 at a posedge -> PRIME.
- PRIME:
  - Captures prev<=sig_in; no evaluation (no past value exists yet).
  - en=1 -> WATCH; en=0 -> IDLE.
- WATCH, each posedge with en=1:
  - changed = (sig_in != prev); then prev<=sig_in.
  - changed: pass_pulse=1 for the next cycle, pass_cnt+1, stall_cnt<=0.
  - Not changed, stall_cnt+1 <= MAX_STALL: stall_cnt<=stall_cnt+1, no pulse.
  - Not changed, stall_cnt+1 > MAX_STALL: fail_pulse=1 for the next cycle, fail_cnt+1, stall_cnt<=0.
- en deasserted in WATCH:
  - -> IDLE at that edge; no evaluation at that edge.
  - Counters are kept; stall_cnt<=0.
  - Re-enabling always passes through PRIME again, so the first sample after re-enable is never evaluated.
- Pulse timing:
  - Pulses are registered, so they are visible in the cycle after the sampling edge.
  - pass_pulse and fail_pulse are never high together.
- Counter arithmetic:
  - pass_cnt and fail_cnt saturate at 2^CNT_W-1 and never wrap.
  - stall_cnt cannot exceed MAX_STALL.
- clr=1:
  - Zeroes pass_cnt, fail_cnt and stall_cnt at that edge, with priority over any increment in the same cycle.
  - A pulse generated at that edge still fires.
  - State and prev are unaffected.
- Reset mid-operation: immediate return to IDLE; any pulse is dropped.
- WIDTH>1: any bit difference counts as a change.

Optional Feature:
- Macro CHANGE_WATCH_STICKY_FAIL_EN.
- Defined:
  - Adds output fail_flag (1 bit, reset 0).
  - fail_flag is set on the same edge that raises fail_pulse.
  - It stays high until clr=1 or rst; clr has priority over a simultaneous set, so the flag ends at 0.
- Undefined: the port and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then en=0 for 10 cycles with sig_in toggling -> state=0, all counters 0, no pulses.
- Toggle every cycle, MAX_STALL=0: en=1, sig_in alternates 0/1 for 8 samples after PRIME -> 8 pass_pulses, pass_cnt=8, fail_cnt=0.
- Stall limit, MAX_STALL=2: sig_in constant for 7 samples after PRIME:
  - stall_cnt goes 1, 2, then fail; the pattern repeats.
  - Result: 2 fail_pulses, fail_cnt=2, stall_cnt=1.
- Re-enable priming: in WATCH, drop en for 1 cycle while sig_in changes, then raise en -> no pulse for the PRIME sample; the next change gives pass_pulse.
- clr with a simultaneous event: pass_cnt=5 and a change occurs with clr=1 -> pass_pulse=1, pass_cnt=0 (and with STICKY_FAIL_EN, fail_flag cleared).
- Async reset mid-WATCH: assert rst between edges -> state=0 and counters 0 immediately; after release, en=1 re-enters via PRIME.

Source files
------------

// File: rtl/change_watch_ctrl.sv
// rtl/change_watch_ctrl.sv - change-watchdog controller flagging per-sample change (pass) or stall (fail)
//
// Purpose:
//   Samples sig_in on every posedge of clk and, while monitoring, flags each
//   sample where the value changed (pass) or where the run of unchanged
//   samples exceeded MAX_STALL (fail). Keeps saturating pass/fail totals and
//   the current stall run length.
//
// Parameters:
//   WIDTH     width of sig_in
//   MAX_STALL consecutive unchanged samples tolerated before a fail
//   CNT_W     width of pass_cnt, fail_cnt and stall_cnt
//
// Ports:
//   clk        sampling clock, posedge
//   rst        asynchronous active-high reset
//   en         monitoring enable (level)
//   clr        synchronous clear of counters and stall tracking
//   sig_in     monitored signal
//   pass_pulse one-cycle pulse, change detected at the previous edge
//   fail_pulse one-cycle pulse, stall limit exceeded at the previous edge
//   pass_cnt   saturating pass total
//   fail_cnt   saturating fail total
//   stall_cnt  current run of unchanged samples
//   state      0=IDLE, 1=PRIME, 2=WATCH
//   busy       high while state != IDLE
//   fail_flag  sticky fail indicator (only with CHANGE_WATCH_STICKY_FAIL_EN)
//
// Optional feature macro: CHANGE_WATCH_STICKY_FAIL_EN

module change_watch_ctrl #(
    parameter int WIDTH     = 1,
    parameter int MAX_STALL = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] sig_in,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state,
    output logic             busy
`ifdef CHANGE_WATCH_STICKY_FAIL_EN
    ,
    output logic             fail_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        WATCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // One extra bit so the stall limit comparison cannot overflow.
    localparam logic [CNT_W:0]   STALL_LIM = (CNT_W+1)'(MAX_STALL);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             pass_pulse_q, pass_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic             busy_q, busy_d;
    logic             flag_q, flag_d;
    logic [CNT_W:0]   stall_inc;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        pass_pulse_d = 1'b0;
        fail_pulse_d = 1'b0;
        flag_d       = flag_q;
        stall_inc    = {1'b0, stall_cnt_q} + 1'b1;

        case (state_q)
            IDLE: begin
                stall_cnt_d = '0;
                if (en) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                // No past value exists yet, so this sample only seeds prev.
                prev_d  = sig_in;
                state_d = en ? WATCH : IDLE;
            end
            WATCH: begin
                if (!en) begin
                    state_d     = IDLE;
                    stall_cnt_d = '0;
                end else begin
                    prev_d = sig_in;
                    if (sig_in != prev_q) begin
                        pass_pulse_d = 1'b1;
                        stall_cnt_d  = '0;
                        if (pass_cnt_q != CNT_MAX) begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                        end
                    end else if (stall_inc <= STALL_LIM) begin
                        stall_cnt_d = stall_inc[CNT_W-1:0];
                    end else begin
                        fail_pulse_d = 1'b1;
                        stall_cnt_d  = '0;
                        flag_d       = 1'b1;
                        if (fail_cnt_q != CNT_MAX) begin
                            fail_cnt_d = fail_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear wins over any increment; pulses computed above still fire.
        if (clr) begin
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
            stall_cnt_d = '0;
            flag_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            busy_q       <= busy_d;
            flag_q       <= flag_d;
        end
    end

    assign pass_pulse = pass_pulse_q;
    assign fail_pulse = fail_pulse_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign state      = state_q;
    assign busy       = busy_q;

`ifdef CHANGE_WATCH_STICKY_FAIL_EN
    assign fail_flag = flag_q;
`else
    // Sticky flag is not exported in this build; keep its logic from dangling.
    logic unused_flag;
    assign unused_flag = flag_q;
`endif

endmodule
